// File: rtl/vga_dither_out.sv
// vga_dither_out
//   Reduces an IN_BITS-per-channel RGB stream to the 2-bit-per-channel TinyVGA
//   pinout, using a 2x2 ordered dither whose offset rotates every frame.
//   Also runs a first-order sigma-delta modulator that turns an unsigned audio
//   sample into a 1-bit pulse-density stream.
//
// Parameters
//   IN_BITS    colour bits per input channel (2..8)
//   AUDIO_BITS audio sample width
//   SYNC_INV   1 inverts hsync/vsync at the output
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   enable          clock enable for the video path (audio always runs)
//   in_rgb          {r,g,b} pixel colour
//   in_hsync/vsync  raw sync levels
//   in_active       high in the visible area
//   in_new_frame    one-cycle pulse at frame start
//   dither_en       1 = ordered dither, 0 = truncation
//   audio_in        unsigned audio sample
//   uo_out          {hs, b0, g0, r0, vs, b1, g1, r1}, one cycle latency
//   uio_out         bit 7 = audio bitstream, others 0
//   uio_oe          fixed 8'b1000_0000
module vga_dither_out #(
  parameter int IN_BITS    = 4,
  parameter int AUDIO_BITS = 8,
  parameter int SYNC_INV   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3*IN_BITS-1:0]  in_rgb,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_active,
  input  logic                  in_new_frame,
  input  logic                  dither_en,
  input  logic [AUDIO_BITS-1:0] audio_in,
  output logic [7:0]            uo_out,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe
);

  localparam int   D        = IN_BITS - 2;
  localparam logic SYNC_POL = (SYNC_INV != 0);

  logic                  r_x_par;
  logic                  r_y_par;
  logic                  r_prev_active;
  logic [1:0]            r_phase;
  logic [7:0]            r_uo;
  logic [AUDIO_BITS-1:0] r_acc;
  logic                  r_carry;

  logic [1:0]            w_bayer;
  logic [1:0]            w_offset;
  logic [IN_BITS-1:0]    w_thr;
  logic [2:0]            w_hi;   // index 2 = r, 1 = g, 0 = b
  logic [2:0]            w_lo;
  logic [7:0]            w_uo_next;

  // 2x2 Bayer cell: (x,y) 00->0, 10->2, 01->3, 11->1
  assign w_bayer  = {r_x_par ^ r_y_par, r_y_par};
  // 2-bit add wraps naturally, giving the mod-4 frame rotation
  assign w_offset = w_bayer + r_phase;

  // Threshold is aligned so its MSB lands just below the kept 2 bits.
  generate
    if (D == 0) begin : g_thr_none
      assign w_thr = '0;
    end else if (D == 1) begin : g_thr_one
      assign w_thr = {{(IN_BITS-1){1'b0}}, w_offset[1] & dither_en};
    end else begin : g_thr_shift
      assign w_thr = dither_en ? ({{(IN_BITS-2){1'b0}}, w_offset} << (D-2)) : '0;
    end
  endgenerate

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    // w_top = {overflow, kept 2 bits} of the widened sum
    logic [2:0] w_top;
    assign w_top    = 3'(({1'b0, in_rgb[ch*IN_BITS +: IN_BITS]} + {1'b0, w_thr}) >> D);
    assign w_hi[ch] = (w_top[2] | w_top[1]) & in_active;
    assign w_lo[ch] = (w_top[2] | w_top[0]) & in_active;
  end

  assign w_uo_next = {in_hsync ^ SYNC_POL, w_lo[0], w_lo[1], w_lo[2],
                      in_vsync ^ SYNC_POL, w_hi[0], w_hi[1], w_hi[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_par       <= 1'b0;
      r_y_par       <= 1'b0;
      r_prev_active <= 1'b0;
      r_phase       <= 2'd0;
      r_uo          <= 8'd0;
    end else if (enable) begin
      r_prev_active <= in_active;
      r_x_par       <= in_active ? ~r_x_par : 1'b0;
      // frame start overrides a coincident end-of-line toggle
      if (in_new_frame) begin
        r_y_par <= 1'b0;
        r_phase <= r_phase + 2'd1;
      end else if (r_prev_active && !in_active) begin
        r_y_par <= ~r_y_par;
      end
      r_uo <= w_uo_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else begin
      {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, audio_in};
    end
  end

  assign uo_out  = r_uo;
  assign uio_out = {r_carry, 7'd0};
  assign uio_oe  = 8'b1000_0000;

endmodule

// File: tb/tb_vga_dither_out.sv
module tb_vga_dither_out;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [11:0] in_rgb;
  logic        in_hsync;
  logic        in_vsync;
  logic        in_active;
  logic        in_new_frame;
  logic        dither_en;
  logic [7:0]  audio_in;
  logic [7:0]  uo_out;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int n_checks = 0;
  int n_pass   = 0;

  vga_dither_out #(.IN_BITS(4), .AUDIO_BITS(8), .SYNC_INV(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_rgb       (in_rgb),
    .in_hsync     (in_hsync),
    .in_vsync     (in_vsync),
    .in_active    (in_active),
    .in_new_frame (in_new_frame),
    .dither_en    (dither_en),
    .audio_in     (audio_in),
    .uo_out       (uo_out),
    .uio_out      (uio_out),
    .uio_oe       (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected pin image from 2-bit channel values and output sync levels
  function automatic logic [7:0] pack(input logic [1:0] r, input logic [1:0] g,
                                      input logic [1:0] b, input logic hs, input logic vs);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic act, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    in_active = act;
    in_rgb    = {r, g, b};
  endtask

  task automatic test_reset();
    #10;
    n_checks++;
    if (uo_out !== 8'h00) $display("FAIL reset_uo: got %h want 00", uo_out); else n_pass++;
    n_checks++;
    if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h want 00", uio_out); else n_pass++;
    n_checks++;
    if (uio_oe !== 8'h80) $display("FAIL reset_uio_oe: got %h want 80", uio_oe); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_dither();
    logic [7:0] e;
    dither_en = 1'b1;
    pix(1'b1, 4'd6, 4'd0, 4'd0);
    step();
    e = pack(2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if ({uo_out[0], uo_out[4]} !== 2'b01) $display("FAIL dither_px0_r: got %b want 01", {uo_out[0], uo_out[4]}); else n_pass++;
    n_checks++;
    if (uo_out !== e) $display("FAIL dither_px0: got %h want %h", uo_out, e); else n_pass++;
    step();
    e = pack(2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if ({uo_out[0], uo_out[4]} !== 2'b10) $display("FAIL dither_px1_r: got %b want 10", {uo_out[0], uo_out[4]}); else n_pass++;
    n_checks++;
    if (uo_out !== e) $display("FAIL dither_px1: got %h want %h", uo_out, e); else n_pass++;
    pix(1'b0, 4'd15, 4'd15, 4'd15);
    step();
    e = pack(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== e) $display("FAIL blank: got %h want %h", uo_out, e); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    // line 2: y_par=1, first pixel at offset 3
    pix(1'b1, 4'd15, 4'd12, 4'd4);
    step();
    e = pack(2'b11, 2'b11, 2'b01, 1'b1, 1'b1);
    n_checks++;
    if ({uo_out[0], uo_out[4]} !== 2'b11) $display("FAIL sat_r: got %b want 11", {uo_out[0], uo_out[4]}); else n_pass++;
    n_checks++;
    if (uo_out !== e) $display("FAIL sat_px0: got %h want %h", uo_out, e); else n_pass++;
    pix(1'b1, 4'd15, 4'd12, 4'd4);
    step();
    n_checks++;
    if (uo_out !== e) $display("FAIL sat_px1: got %h want %h", uo_out, e); else n_pass++;
    dither_en = 1'b0;
    pix(1'b1, 4'd6, 4'd9, 4'd3);
    step();
    e = pack(2'b01, 2'b10, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== e) $display("FAIL truncate: got %h want %h", uo_out, e); else n_pass++;
    dither_en = 1'b1;
    pix(1'b0, 4'd0, 4'd0, 4'd0);
    step();
  endtask

  task automatic test_frame();
    logic [7:0] exp_tab [5];
    exp_tab[0] = pack(2'b01, 2'b00, 2'b00, 1'b1, 1'b1);  // phase 1
    exp_tab[1] = pack(2'b01, 2'b01, 2'b00, 1'b1, 1'b1);  // phase 2
    exp_tab[2] = pack(2'b01, 2'b01, 2'b01, 1'b1, 1'b1);  // phase 3
    exp_tab[3] = pack(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);  // phase 0
    exp_tab[4] = pack(2'b01, 2'b00, 2'b00, 1'b1, 1'b1);  // phase 1
    for (int i = 0; i < 5; i++) begin
      // rounds after the first land new_frame on an active falling edge
      pix(1'b0, 4'd0, 4'd0, 4'd0);
      in_new_frame = 1'b1;
      step();
      in_new_frame = 1'b0;
      pix(1'b1, 4'd3, 4'd2, 4'd1);
      step();
      n_checks++;
      if (uo_out !== exp_tab[i]) $display("FAIL frame_round%0d: got %h want %h", i, uo_out, exp_tab[i]); else n_pass++;
    end
    pix(1'b0, 4'd0, 4'd0, 4'd0);
    step();
  endtask

  task automatic test_enable();
    logic [7:0] e;
    pix(1'b1, 4'd15, 4'd15, 4'd15);
    step();
    e = 8'hFF;
    n_checks++;
    if (uo_out !== e) $display("FAIL enable_pre: got %h want %h", uo_out, e); else n_pass++;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix(i[0], 4'd0, 4'd0, 4'd0);
      in_hsync     = 1'b1;
      in_new_frame = ~i[0];
      step();
      n_checks++;
      if (uo_out !== e) $display("FAIL enable_hold%0d: got %h want %h", i, uo_out, e); else n_pass++;
    end
    enable       = 1'b1;
    in_hsync     = 1'b0;
    in_new_frame = 1'b0;
    pix(1'b1, 4'd3, 4'd2, 4'd1);
    step();
    e = pack(2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== e) $display("FAIL enable_resume: got %h want %h", uo_out, e); else n_pass++;
  endtask

  task automatic test_sync();
    logic [7:0] e;
    pix(1'b0, 4'd15, 4'd15, 4'd15);
    in_hsync = 1'b1;
    in_vsync = 1'b0;
    step();
    e = pack(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    n_checks++;
    if (uo_out !== e) $display("FAIL sync_hs: got %h want %h", uo_out, e); else n_pass++;
    in_hsync = 1'b0;
    in_vsync = 1'b1;
    step();
    e = pack(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (uo_out !== e) $display("FAIL sync_vs: got %h want %h", uo_out, e); else n_pass++;
    in_vsync = 1'b0;
  endtask

  task automatic test_audio();
    int ones;
    int bad;
    enable   = 1'b0;
    audio_in = 8'd64;
    ones = 0;
    bad  = 0;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (uio_out[7] === 1'b1) ones++;
      if (uio_out[7] !== ((i % 4) == 0)) bad++;
      if (uio_out[6:0] !== 7'd0) bad++;
    end
    n_checks++;
    if (ones != 64) $display("FAIL audio_density: got %0d ones want 64", ones); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL audio_spacing: got %0d bad cycles want 0", bad); else n_pass++;
    audio_in = 8'd0;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (uio_out !== 8'h00) ones++;
    end
    n_checks++;
    if (ones != 0) $display("FAIL audio_zero: got %0d nonzero cycles want 0", ones); else n_pass++;
    enable = 1'b1;
  endtask

  task automatic test_reset_midline();
    logic [7:0] e;
    pix(1'b0, 4'd0, 4'd0, 4'd0);
    in_new_frame = 1'b1;
    step();
    in_new_frame = 1'b0;
    pix(1'b1, 4'd3, 4'd2, 4'd1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (uo_out !== 8'h00) $display("FAIL midreset_async: got %h want 00", uo_out); else n_pass++;
    n_checks++;
    if (uio_oe !== 8'h80) $display("FAIL midreset_oe: got %h want 80", uio_oe); else n_pass++;
    step();
    n_checks++;
    if (uo_out !== 8'h00) $display("FAIL midreset_hold: got %h want 00", uo_out); else n_pass++;
    rst_n = 1'b1;
    step();
    e = pack(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== e) $display("FAIL midreset_px0: got %h want %h", uo_out, e); else n_pass++;
    step();
    e = pack(2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== e) $display("FAIL midreset_px1: got %h want %h", uo_out, e); else n_pass++;
  endtask

  initial begin
    rst_n        = 1'b1;
    enable       = 1'b1;
    in_rgb       = '0;
    in_hsync     = 1'b0;
    in_vsync     = 1'b0;
    in_active    = 1'b0;
    in_new_frame = 1'b0;
    dither_en    = 1'b1;
    audio_in     = 8'd0;
    #2;
    rst_n = 1'b0;
    test_reset();
    test_dither();
    test_saturation();
    test_frame();
    test_enable();
    test_sync();
    test_audio();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
